reg_busy_scoreboard: RTL and testbench
======================================

Name: reg_busy_scoreboard

Overview:
- Parametrised register-busy scoreboard for the pipelined processor.
- Tracks which architectural registers have an outstanding long-latency write (multdiv, loads).
- Uses generalised one-hot decode masks to set busy bits on issue and clear them on writeback.
- Provides source-hazard and WAW-stall indications to the decode/issue stage.

Parameters:
ADDR_W, 5, register index width
NUM_REGS, 32, number of tracked registers (must equal 2**ADDR_W)
ZERO_HARDWIRED, 1, when 1 register 0 is never marked busy

Ports:
clock  input  1  single system clock, all state on rising edge
reset_n  input  1  synchronous active-low reset
flush  input  1  clear all busy bits (pipeline squash)
issue_valid  input  1  producer requests to mark a destination busy
issue_rd  input  ADDR_W  destination register of the issuing op
issue_ready  output  1  issue accepted this cycle when issue_valid & issue_ready
wb_valid  input  1  writeback completes for wb_rd
wb_rd  input  ADDR_W  register being written back
rs1  input  ADDR_W  source 1 of the instruction in decode
rs2  input  ADDR_W  source 2 of the instruction in decode
hazard  output  1  a source is busy and not being written back this cycle
busy_vec  output  NUM_REGS  registered busy bits, bit i = register i
busy_count  output  ADDR_W+1  number of set bits in busy_vec (registered)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at a clock edge): busy_vec=0 and busy_count=0. issue_ready and hazard then evaluate combinationally from the cleared state, so hazard=0 and issue_ready=1.
- reset_n has priority over flush; flush has priority over issue and wb.
- Decode: set_mask = onehot(issue_rd, issue_valid & issue_ready); clr_mask = onehot(wb_rd, wb_valid).
- Next state: busy_next = (busy_vec & ~clr_mask) | set_mask.
  - Same register set and cleared in one cycle ends busy (set wins).
- ZERO_HARDWIRED=1: bit 0 is forced 0 in set_mask and in the register.
  - Issue to r0 is always accepted and is a no-op.
  - rs=0 never hazards.
- issue_ready (combinational): 1 unless busy_vec[issue_rd] is set and not cleared by wb this cycle. This is the WAW stall. It is independent of issue_valid.
- hazard (combinational): for each source rsX, the source is hazardous when busy_vec[rsX] is set and not (wb_valid and wb_rd==rsX), because writeback data is bypassed. hazard is the OR of both sources.
  - Same-cycle issue to rsX does not raise hazard this cycle; it does from the next cycle.
- wb to a non-busy register: legal and ignored, no error.
- Latency:
  - busy_vec and busy_count update one cycle after the accepted issue or wb.
  - hazard and issue_ready respond the same cycle to busy_vec, wb and rs inputs.
- busy_count: registered population count of busy_next. Never exceeds NUM_REGS-ZERO_HARDWIRED.
- flush=1: busy_vec and busy_count go to 0 next cycle. issue_ready stays combinational, but an issue accepted during flush is discarded.
- Reset mid-operation: all pending state is dropped. Late writebacks after reset are ignored, since clearing an already-clear bit is harmless.

Decomposition:
- Shared package constants: ADDR_W, NUM_REGS, REG_ZERO index.
- One sub-module: onehot_decode. It is a parametrised (ADDR_W, width 2**ADDR_W) combinational decoder, index plus enable to one-hot, built as a log-stage shift chain. It is instantiated twice (set and clear masks).
- Popcount is a function or generate adder tree inside the top module.

Test Plan:
- Reset then issue r5, next cycle rs1=5 -> busy_vec=0x00000020, busy_count=1, hazard=1, issue_ready for rd=5 =0.
- Busy r5, wb_valid with wb_rd=5 and rs2=5 in the same cycle -> hazard=0, issue_ready(rd=5)=1. Next cycle busy_vec=0 (or 0x20 if issue_valid for rd 5 in the same cycle).
- Issue rd=0 and rs1=0 -> issue_ready=1, busy_vec stays 0, hazard=0, busy_count=0.
- Issue r1..r31 over 31 cycles -> busy_vec=0xFFFFFFFE, busy_count=31. Then flush=1 -> next cycle busy_vec=0, busy_count=0.
- Busy r3 and r7, reset_n=0 for one cycle with concurrent issue rd=9 -> busy_vec=0. A later wb_rd=3 leaves busy_vec=0.
- Parameter sweep ADDR_W=3 (NUM_REGS=8), ZERO_HARDWIRED=0: issue rd=0 -> busy_vec=0x01, rs1=0 -> hazard=1.

Source files
------------

// File: rtl/reg_busy_scoreboard_pkg.sv
// Shared constants for the register-busy scoreboard.
package reg_busy_scoreboard_pkg;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/reg_busy_scoreboard_onehot_decode.sv
// Index-plus-enable to one-hot decoder, built as a log-depth chain of
// conditional power-of-two shifts.
module onehot_decode #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      idx,
  input  logic                   en,
  output logic [(1<<ADDR_W)-1:0] onehot
);
  localparam int unsigned WIDTH = 1 << ADDR_W;

  logic [WIDTH-1:0] stage [ADDR_W+1];

  assign stage[0] = WIDTH'(en);

  for (genvar i = 0; i < ADDR_W; i++) begin : g_stage
    assign stage[i+1] = idx[i] ? (stage[i] << (1 << i)) : stage[i];
  end

  assign onehot = stage[ADDR_W];
endmodule

// File: rtl/reg_busy_scoreboard.sv
// Register-busy scoreboard: tracks outstanding long-latency writes and
// reports source hazards and WAW stalls to decode/issue.
module reg_busy_scoreboard
  import reg_busy_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W         = reg_busy_scoreboard_pkg::ADDR_W,
  parameter int unsigned NUM_REGS       = reg_busy_scoreboard_pkg::NUM_REGS,
  parameter bit          ZERO_HARDWIRED = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [ADDR_W:0]     busy_count
);
  logic [NUM_REGS-1:0] set_raw;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] keep_mask;
  logic [NUM_REGS-1:0] busy_next;
  logic                issue_go;
  logic                rs1_haz;
  logic                rs2_haz;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      cnt = cnt + (ADDR_W+1)'(v[i]);
    end
    return cnt;
  endfunction

  assign issue_go = issue_valid & issue_ready;

  onehot_decode #(.ADDR_W(ADDR_W)) u_set_dec (
    .idx    (issue_rd),
    .en     (issue_go),
    .onehot (set_raw)
  );

  onehot_decode #(.ADDR_W(ADDR_W)) u_clr_dec (
    .idx    (wb_rd),
    .en     (wb_valid),
    .onehot (clr_mask)
  );

  // Register zero can never become busy when it is hardwired.
  always_comb begin
    keep_mask = '1;
    if (ZERO_HARDWIRED) keep_mask[REG_ZERO] = 1'b0;
  end

  assign set_mask  = set_raw & keep_mask;
  assign busy_next = ((busy_vec & ~clr_mask) | set_mask) & keep_mask;

  // Same-cycle writeback is bypassed, so it hides both stalls.
  assign issue_ready = ~(busy_vec[issue_rd] & ~(wb_valid & (wb_rd == issue_rd)));
  assign rs1_haz     = busy_vec[rs1] & ~(wb_valid & (wb_rd == rs1));
  assign rs2_haz     = busy_vec[rs2] & ~(wb_valid & (wb_rd == rs2));
  assign hazard      = rs1_haz | rs2_haz;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy_vec   <= '0;
      busy_count <= '0;
    end else if (flush) begin
      busy_vec   <= '0;
      busy_count <= '0;
    end else begin
      busy_vec   <= busy_next;
      busy_count <= popcount(busy_next);
    end
  end
endmodule

// File: tb/tb_reg_busy_scoreboard.sv
// Scoreboard bench: directed vectors push expected outputs, a negedge
// monitor pops and compares against the default and a small-config DUT.
module tb_reg_busy_scoreboard;
  logic clock = 1'b0;
  logic reset_n, flush;

  logic       a_iv, a_wv, a_rdy, a_haz;
  logic [4:0] a_ird, a_wrd, a_rs1, a_rs2;
  logic [31:0] a_busy;
  logic [5:0]  a_cnt;

  logic       b_iv, b_wv, b_rdy, b_haz;
  logic [2:0] b_ird, b_wrd, b_rs1, b_rs2;
  logic [7:0] b_busy;
  logic [3:0] b_cnt;

  typedef struct {
    bit          sel_b;
    bit          chk;
    string       name;
    logic [31:0] busy;
    logic [5:0]  cnt;
    logic        haz;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  always #5 clock = ~clock;

  reg_busy_scoreboard dut_a (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .issue_valid (a_iv),
    .issue_rd    (a_ird),
    .issue_ready (a_rdy),
    .wb_valid    (a_wv),
    .wb_rd       (a_wrd),
    .rs1         (a_rs1),
    .rs2         (a_rs2),
    .hazard      (a_haz),
    .busy_vec    (a_busy),
    .busy_count  (a_cnt)
  );

  reg_busy_scoreboard #(.ADDR_W(3), .NUM_REGS(8), .ZERO_HARDWIRED(1'b0)) dut_b (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .issue_valid (b_iv),
    .issue_rd    (b_ird),
    .issue_ready (b_rdy),
    .wb_valid    (b_wv),
    .wb_rd       (b_wrd),
    .rs1         (b_rs1),
    .rs2         (b_rs2),
    .hazard      (b_haz),
    .busy_vec    (b_busy),
    .busy_count  (b_cnt)
  );

  task automatic check(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] req);
    checks_total++;
    if (act === req) checks_passed++;
    else $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, req);
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        if (e.sel_b) begin
          check(e.name, "busy_vec",    32'(b_busy), e.busy);
          check(e.name, "busy_count",  32'(b_cnt),  32'(e.cnt));
          check(e.name, "hazard",      32'(b_haz),  32'(e.haz));
          check(e.name, "issue_ready", 32'(b_rdy),  32'(e.rdy));
        end else begin
          check(e.name, "busy_vec",    a_busy,      e.busy);
          check(e.name, "busy_count",  32'(a_cnt),  32'(e.cnt));
          check(e.name, "hazard",      32'(a_haz),  32'(e.haz));
          check(e.name, "issue_ready", 32'(a_rdy),  32'(e.rdy));
        end
      end
    end
  end

  task automatic push(input bit sel_b, input bit chk, input string name,
                      input logic [31:0] busy, input logic [5:0] cnt,
                      input logic haz, input logic rdy);
    exp_t e;
    e.sel_b = sel_b; e.chk = chk; e.name = name;
    e.busy = busy; e.cnt = cnt; e.haz = haz; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  // Drive DUT A for one cycle; expectation covers outputs seen this cycle.
  task automatic step_a(input logic rst, input logic fl, input logic iv, input int ird,
                        input logic wv, input int wrd, input int r1, input int r2,
                        input bit chk, input string name, input logic [31:0] busy,
                        input int cnt, input logic haz, input logic rdy);
    @(posedge clock);
    #1;
    reset_n = rst; flush = fl;
    a_iv = iv; a_ird = 5'(ird); a_wv = wv; a_wrd = 5'(wrd);
    a_rs1 = 5'(r1); a_rs2 = 5'(r2);
    b_iv = 1'b0; b_wv = 1'b0;
    push(1'b0, chk, name, busy, 6'(cnt), haz, rdy);
  endtask

  task automatic step_b(input logic fl, input logic iv, input int ird,
                        input logic wv, input int wrd, input int r1, input int r2,
                        input string name, input logic [31:0] busy,
                        input int cnt, input logic haz, input logic rdy);
    @(posedge clock);
    #1;
    reset_n = 1'b1; flush = fl;
    b_iv = iv; b_ird = 3'(ird); b_wv = wv; b_wrd = 3'(wrd);
    b_rs1 = 3'(r1); b_rs2 = 3'(r2);
    a_iv = 1'b0; a_wv = 1'b0;
    push(1'b1, 1'b1, name, busy, 6'(cnt), haz, rdy);
  endtask

  initial begin
    int budget;
    logic [63:0] one64;
    reset_n = 1'b0; flush = 1'b0;
    a_iv = 0; a_ird = 0; a_wv = 0; a_wrd = 0; a_rs1 = 0; a_rs2 = 0;
    b_iv = 0; b_ird = 0; b_wv = 0; b_wrd = 0; b_rs1 = 0; b_rs2 = 0;

    //     rst fl iv ird wv wrd rs1 rs2 chk name            busy       cnt haz rdy
    step_a(0, 0, 0, 0,  0, 0,  0,  0,  0, "pre_reset",       32'h0,      0, 0, 1);
    step_a(1, 0, 0, 0,  0, 0,  0,  0,  1, "reset",           32'h0,      0, 0, 1);
    step_a(1, 0, 1, 5,  0, 0,  5,  0,  1, "same_cycle_iss",  32'h0,      0, 0, 1);
    step_a(1, 0, 0, 5,  0, 0,  5,  0,  1, "issue_r5",        32'h20,     1, 1, 0);
    step_a(1, 0, 1, 5,  1, 5,  0,  5,  1, "wb_bypass",       32'h20,     1, 0, 1);
    step_a(1, 0, 0, 5,  0, 0,  5,  0,  1, "set_wins",        32'h20,     1, 1, 0);
    step_a(1, 0, 0, 0,  1, 5,  0,  0,  1, "wb_only",         32'h20,     1, 0, 1);
    step_a(1, 0, 0, 5,  0, 0,  5,  0,  1, "cleared",         32'h0,      0, 0, 1);
    step_a(1, 0, 1, 0,  0, 0,  0,  0,  1, "r0_issue",        32'h0,      0, 0, 1);
    step_a(1, 0, 0, 0,  0, 0,  0,  0,  1, "r0_noop",         32'h0,      0, 0, 1);
    step_a(1, 0, 0, 0,  1, 9,  0,  0,  1, "wb_nonbusy",      32'h0,      0, 0, 1);

    // Fill r1..r31: before issuing ri, registers 1..i-1 are busy.
    one64 = 64'd1;
    for (int i = 1; i < 32; i++) begin
      step_a(1, 0, 1, i, 0, 0, i, 0, 1, "fill",
             32'((one64 << i) - 64'd2), i - 1, 0, 1);
    end
    step_a(1, 1, 1, 4,  0, 0,  31, 0,  1, "full",            32'hFFFFFFFE, 31, 1, 0);
    step_a(1, 1, 1, 6,  0, 0,  31, 0,  1, "flushed",         32'h0,      0, 0, 1);
    step_a(1, 0, 0, 6,  0, 0,  6,  0,  1, "flush_discard",   32'h0,      0, 0, 1);

    step_a(1, 0, 1, 3,  0, 0,  0,  0,  1, "iss_r3",          32'h0,      0, 0, 1);
    step_a(1, 0, 1, 7,  0, 0,  0,  0,  1, "iss_r7",          32'h8,      1, 0, 1);
    step_a(0, 0, 1, 9,  0, 0,  0,  7,  1, "rs2_haz_reset",   32'h88,     2, 1, 1);
    step_a(1, 0, 0, 0,  1, 3,  3,  7,  1, "after_reset",     32'h0,      0, 0, 1);
    step_a(1, 0, 0, 9,  0, 0,  3,  9,  1, "late_wb",         32'h0,      0, 0, 1);

    //     fl iv ird wv wrd rs1 rs2 name           busy    cnt haz rdy
    step_b(0, 1, 0,  0, 0,  0,  0,  "b_iss_r0",    32'h0,  0, 0, 1);
    step_b(0, 0, 0,  0, 0,  0,  0,  "b_r0_busy",   32'h01, 1, 1, 0);
    step_b(0, 1, 7,  0, 0,  7,  7,  "b_iss_r7",    32'h01, 1, 0, 1);
    step_b(1, 0, 7,  0, 0,  7,  0,  "b_two_busy",  32'h81, 2, 1, 0);
    step_b(0, 0, 7,  0, 0,  7,  0,  "b_flushed",   32'h0,  0, 0, 1);

    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      @(posedge clock);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks_total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
